// File: rtl/tlv5638_pkg.sv
// rtl/tlv5638_pkg.sv - shared constants and types for the TLV5638 serial receiver
package tlv5638_pkg;

  localparam int FRAME_BITS = 16;

  // R1R0 command codes taken from W[15] and W[12]
  localparam logic [1:0] CMD_WR_B   = 2'b00;
  localparam logic [1:0] CMD_WR_BUF = 2'b01;
  localparam logic [1:0] CMD_WR_A   = 2'b10;
  localparam logic [1:0] CMD_CTRL   = 2'b11;

  // Reference select codes
  localparam logic [1:0] REF_EXT     = 2'b00;
  localparam logic [1:0] REF_1V024   = 2'b01;
  localparam logic [1:0] REF_2V048   = 2'b10;
  localparam logic [1:0] REF_EXT_ALT = 2'b11;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DECODE    = 2'd3
  } rx_state_t;

endpackage

// File: rtl/tlv5638_rx_sync_edge.sv
// rtl/tlv5638_rx_sync_edge.sv - 2-FF synchroniser with rise/fall detection
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_50,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two flops to settle metastability, a third remembers the last settled level
  always_ff @(posedge clk_50) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/tlv5638_rx.sv
// rtl/tlv5638_rx.sv - TLV5638 DAC serial frame receiver and register decoder
module tlv5638_rx #(
  parameter int FRAME_BITS = tlv5638_pkg::FRAME_BITS,
  parameter int MIN_HALF   = 3
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        din,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] buf_q,
  output logic [1:0]  ref_sel,
  output logic        speed,
  output logic        pwr_dn,
  output logic        upd_a,
  output logic        upd_b,
  output logic        ctrl_upd,
  output logic        frame_err,
  output logic        busy
);

  import tlv5638_pkg::*;

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  // Each sclk level must last long enough to cross the synchroniser and be seen
  if (MIN_HALF < 2) begin : g_min_half_check
    $error("MIN_HALF must be at least 2 clk_50 cycles");
  end

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  cs_lvl;
  logic                  cs_rise;
  logic                  cs_fall;
  logic                  sclk_lvl;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  din_meta;
  logic                  din_sync;
  logic                  sclk_unused;

  // cs_n resets to 0 so a frame already running at reset release is never taken as idle
  sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk_50   (clk_50),
    .rst      (rst),
    .async_in (cs_n),
    .level    (cs_lvl),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk_50   (clk_50),
    .rst      (rst),
    .async_in (sclk),
    .level    (sclk_lvl),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  assign sclk_unused = sclk_lvl ^ sclk_rise;

  // din takes the same two-flop path as sclk so it stays aligned with the detected fall
  always_ff @(posedge clk_50) begin
    if (rst) begin
      din_meta <= 1'b0;
      din_sync <= 1'b0;
    end else begin
      din_meta <= din;
      din_sync <= din_meta;
    end
  end

  // State register
  always_ff @(posedge clk_50) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and busy flag
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_lvl) state_nxt = IDLE;
      IDLE:      if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cs_rise) state_nxt = DECODE;
      end
      DECODE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // Shift capture, frame decode and one-cycle strobes
  always_ff @(posedge clk_50) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      dac_a     <= '0;
      dac_b     <= '0;
      buf_q     <= '0;
      ref_sel   <= REF_EXT;
      speed     <= 1'b0;
      pwr_dn    <= 1'b0;
      upd_a     <= 1'b0;
      upd_b     <= 1'b0;
      ctrl_upd  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      upd_a     <= 1'b0;
      upd_b     <= 1'b0;
      ctrl_upd  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SHIFT: begin
          // A simultaneous cs_n rise ends the frame; that sclk edge is dropped
          if (!cs_rise && sclk_fall) begin
            shreg <= {shreg[FRAME_BITS-2:0], din_sync};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        DECODE: begin
          if (bit_cnt == CNT_FULL) begin
            speed  <= shreg[14];
            pwr_dn <= shreg[13];
            case ({shreg[15], shreg[12]})
              CMD_WR_B: begin
                dac_b <= shreg[11:0];
                buf_q <= shreg[11:0];
                upd_b <= 1'b1;
              end
              CMD_WR_BUF: buf_q <= shreg[11:0];
              CMD_WR_A: begin
                dac_a <= shreg[11:0];
                dac_b <= buf_q;
                upd_a <= 1'b1;
                upd_b <= 1'b1;
              end
              default: begin
                ref_sel  <= shreg[1:0];
                ctrl_upd <= 1'b1;
              end
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tlv5638_rx.md
TLV5638_RX -- requirements
Module: tlv5638_rx

Interface
REQ-001 SHALL declare parameter FRAME_BITS, default 16, bits per valid frame.
REQ-002 SHALL declare parameter MIN_HALF, default 3, minimum sclk high/low time in clk_50 cycles that the block supports.
REQ-003 clk_50  in  1  system clock; one clock; all logic rises on clk_50.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cs_n  in  1  frame select, asynchronous to clk_50, low = frame active.
REQ-006 sclk  in  1  serial clock, asynchronous; din valid at its falling edge.
REQ-007 din  in  1  serial data, MSB first.
REQ-008 dac_a  out  12  DAC A latched code.
REQ-009 dac_b  out  12  DAC B latched code.
REQ-010 buf_q  out  12  double-buffer contents.
REQ-011 ref_sel  out  2  reference select (00 ext, 01 1.024 V, 10 2.048 V, 11 ext).
REQ-012 speed  out  1  last decoded SPD bit (D14).
REQ-013 pwr_dn  out  1  last decoded PWR bit (D13).
REQ-014 upd_a / upd_b / ctrl_upd  out  1 each  one-cycle update strobes.
REQ-015 frame_err  out  1  one-cycle strobe on a bad frame.
REQ-016 busy  out  1  high while a frame is being shifted in.

Function
REQ-017 cs_n, sclk and din SHALL each pass a 2-FF synchroniser; sclk and cs_n edges SHALL be detected on the synchronised copies.
REQ-018 FSM states: WAIT_IDLE (cs_n must be seen high), IDLE, SHIFT, DECODE.
- WAIT_IDLE->IDLE on synced cs_n high.
- IDLE->SHIFT on cs_n fall; clears bit count and shift register.
- SHIFT->DECODE on cs_n rise.
- DECODE->IDLE unconditionally after 1 cycle.
REQ-019 In SHIFT, each synced sclk falling edge SHALL shift din into the LSB and increment a 5-bit count that saturates at FRAME_BITS+1.
REQ-020 A cs_n rise and an sclk fall detected in the same cycle SHALL let the cs_n rise win; that sclk edge is ignored.
REQ-021 In DECODE with count==FRAME_BITS, word W SHALL decode on R1=W[15], R0=W[12]:
- 00: dac_b<=W[11:0], buf_q<=W[11:0], upd_b=1.
- 01: buf_q<=W[11:0] only, no strobe.
- 10: dac_a<=W[11:0], dac_b<=buf_q (old value), upd_a=upd_b=1.
- 11: ref_sel<=W[1:0], ctrl_upd=1; dac/buf unchanged.
- speed<=W[14] and pwr_dn<=W[13] SHALL be updated for every valid frame.
REQ-022 In DECODE with count!=FRAME_BITS (short or overrun), frame_err SHALL pulse 1 cycle and no register SHALL change.
REQ-023 Registered outputs and strobes SHALL change on the same clk_50 edge, no later than 4 clk_50 cycles after the cs_n pin rise.
REQ-024 Strobes SHALL be exactly 1 cycle wide; back-to-back frames SHALL each yield their own strobe.
REQ-025 busy SHALL be 1 in SHIFT and DECODE, else 0.
REQ-026 Correct capture is SHALL only for sclk high/low each >= MIN_HALF cycles; faster sclk is out of scope and need not be detected.

Reset
REQ-027 On rst: dac_a=dac_b=buf_q=0, ref_sel=00, speed=0, pwr_dn=0, all strobes 0, busy=0, count=0, state=WAIT_IDLE.
REQ-028 rst mid-frame SHALL discard the partial frame; no strobe SHALL issue for it.
REQ-029 If cs_n is low at reset release, that frame SHALL be ignored until cs_n is seen high.

Structure
REQ-030 Package tlv5638_pkg SHALL hold FRAME_BITS, the R1R0 codes (CMD_WR_B, CMD_WR_BUF, CMD_WR_A, CMD_CTRL) and the REF_* codes, shared with tlv_5638.
REQ-031 Sub-module sync_edge (2-FF synchroniser + rise/fall detect) SHALL be instantiated for cs_n and sclk; din uses its synchroniser only.

Verification
REQ-032 Frame 0xD002 -> ref_sel=10, ctrl_upd 1 cycle, dac_a/dac_b stay 0.
REQ-033 Frame 0x1456 then 0xC123 -> after the first frame buf_q=0x456 with no strobe; after the second dac_a=0x123, dac_b=0x456, upd_a and upd_b in the same cycle.
REQ-034 Frame 0x4ABC -> dac_b=0xABC, buf_q=0xABC, upd_b, speed=1, pwr_dn=0.
REQ-035 12-bit frame, then 17-bit frame -> frame_err pulsed each time; all outputs unchanged.
REQ-036 rst after 8 bits of 0xC7FF, then frame 0x4555 -> no strobe for the aborted frame; dac_b=0x555, dac_a=0.
REQ-037 Paced by tlv_5638 (25-cycle sclk half-period) -> dac_a/dac_b track its ab/data inputs exactly.
